// File: rtl/alu_result_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_buffer_pkg
//  Description : Shared constants and entry type for the ALU result buffer
//                (datapath width, ALU latency, entry width).
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_result_buffer_pkg;

    // Datapath width of pipeline_alu; the buffer must match it.
    localparam int RB_WORD    = 8;
    // pipeline_alu latency; results still in flight when credit drops.
    localparam int RB_ALU_LAT = 2;
    // Stored entry: {cf, zero, result}.
    localparam int RB_ENTRY_W = RB_WORD + 2;

    typedef struct packed {
        logic               cf;
        logic               zero;
        logic [RB_WORD-1:0] result;
    } rb_entry_t;

endpackage : alu_result_buffer_pkg
`default_nettype wire

// File: rtl/rb_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : rb_fifo_mem
//  Description : DEPTH x ENTRY_W register array, one synchronous write port
//                and one asynchronous read port. Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module rb_fifo_mem
    import alu_result_buffer_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = RB_ENTRY_W
) (
    input  logic                       i_clk,
    input  logic                       i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_waddr,
    input  logic [ENTRY_W-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0]   i_raddr,
    output logic [ENTRY_W-1:0]         o_rdata
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    // Storage write; no reset because contents are don't-care after reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule : rb_fifo_mem
`default_nettype wire

// File: rtl/alu_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_buffer
//  Description : Captures every valid pipeline_alu output into a small FIFO,
//                presents it through valid/ready, issues an almost-full
//                credit back to the issuer and flags dropped results.
//                Optional macro ALU_RB_STATS_EN adds push / carry counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_result_buffer
    import alu_result_buffer_pkg::*;
#(
    parameter int WIDTH   = RB_WORD,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = RB_ALU_LAT
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_valid,
    input  logic [WIDTH-1:0]           i_result,
    input  logic                       i_zero,
    input  logic                       i_cf,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [WIDTH-1:0]           o_result,
    output logic                       o_zero,
    output logic                       o_cf,
    output logic                       o_afull,
    output logic                       o_overflow,
    output logic [$clog2(DEPTH):0]     o_count
`ifdef ALU_RB_STATS_EN
    ,
    output logic [15:0]                o_push_cnt,
    output logic [15:0]                o_carry_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = WIDTH + 2;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    // Credit threshold leaves ALU_LAT slots for results already in flight.
    localparam logic [CW-1:0] AFULL_CNT = CW'(DEPTH - ALU_LAT);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          afull_q, afull_d;
    logic          ovf_q, ovf_d;
    logic          w_push, w_pop, w_drop, w_nonempty;
    logic [EW-1:0] w_wdata, w_rdata;

    // Handshake decode and next-state for pointers, occupancy and flags.
    always_comb begin
        w_nonempty = (count_q != '0);
        w_pop      = w_nonempty && i_ready;
        // A full buffer still accepts when the head leaves in the same cycle.
        w_push     = i_valid && ((count_q != FULL_CNT) || w_pop);
        w_drop     = i_valid && (count_q == FULL_CNT) && !w_pop;
        wptr_d     = w_push ? (wptr_q + AW'(1)) : wptr_q;
        rptr_d     = w_pop  ? (rptr_q + AW'(1)) : rptr_q;
        count_d    = count_q + CW'(w_push) - CW'(w_pop);
        afull_d    = (count_d >= AFULL_CNT);
        ovf_d      = ovf_q || w_drop;
        w_wdata    = {i_cf, i_zero, i_result};
    end

    // Control state; async reset so outputs clear without waiting for a clock.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    rb_fifo_mem #(
        .DEPTH   (DEPTH),
        .ENTRY_W (EW)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_push),
        .i_waddr (wptr_q),
        .i_wdata (w_wdata),
        .i_raddr (rptr_q),
        .o_rdata (w_rdata)
    );

    // Head presentation; stale storage is masked to zero while empty.
    always_comb begin
        o_valid  = w_nonempty;
        o_result = w_nonempty ? w_rdata[WIDTH-1:0] : '0;
        o_zero   = w_nonempty && w_rdata[WIDTH];
        o_cf     = w_nonempty && w_rdata[WIDTH+1];
    end

    assign o_afull    = afull_q;
    assign o_overflow = ovf_q;
    assign o_count    = count_q;

`ifdef ALU_RB_STATS_EN
    logic [15:0] push_cnt_q, carry_cnt_q;

    // Accepted-push and accepted-carry counters; drops are not counted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            push_cnt_q  <= '0;
            carry_cnt_q <= '0;
        end else if (w_push) begin
            push_cnt_q  <= push_cnt_q + 16'd1;
            if (i_cf) begin
                carry_cnt_q <= carry_cnt_q + 16'd1;
            end
        end
    end

    assign o_push_cnt  = push_cnt_q;
    assign o_carry_cnt = carry_cnt_q;
`endif

endmodule : alu_result_buffer
`default_nettype wire
